rob_queue: RTL and testbench

Parametrised reorder buffer for the out-of-order core: allocates entries in program order at issue, accepts results from NCDB broadcast ports, exposes operand lookup ports to the reservation stations, and retires one entry per cycle in order to the register file, store path and fetch redirect. It is the next generation of the 16-entry single-mode ROB: generic depth, width and CDB count, real reset, full/empty back-pressure, and misprediction flush.

---
 rtl/rob_pkg.sv | 44 ++++
 rtl/rob_cdb_merge.sv | 46 ++++
 rtl/rob_queue.sv | 237 +++++++++++++++++++++++
 tb/tb_rob_queue.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared types for the reorder buffer.
//   rob_kind_e   - instruction class held by each entry
//   rob_status_t - per-entry control/status fields (valid, ready, mispredict,
//                  kind, sub, rd). The XLEN-wide data/addr payload of an entry
//                  lives in parallel arrays in rob_queue, because XLEN is a
//                  module parameter.
// Optional feature macro consumed by rob_queue: ROB_CDB_BYPASS_EN.
package rob_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DEFAULT_XLEN  = 32;
    localparam int unsigned KIND_W        = 3;
    localparam int unsigned SUB_W         = 3;
    localparam int unsigned REG_W         = 5;

    typedef enum logic [KIND_W-1:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JUMP   = 3'd4,
        KIND_HALT   = 3'd5
    } rob_kind_e;

    typedef struct packed {
        logic             valid;
        logic             ready;
        logic             mispredict;
        rob_kind_e        kind;
        logic [SUB_W-1:0] sub;
        logic [REG_W-1:0] rd;
    } rob_status_t;

    // Kinds that retire through the register file.
    function automatic logic kind_writes_rd(input rob_kind_e k);
        return (k == KIND_ALU) || (k == KIND_LOAD) || (k == KIND_JUMP);
    endfunction

    // Kinds whose mispredict flag triggers a redirect and flush.
    function automatic logic kind_is_ctrl(input rob_kind_e k);
        return (k == KIND_BRANCH) || (k == KIND_JUMP);
    endfunction

endpackage

// File: rtl/rob_cdb_merge.sv
// rob_cdb_merge: per-entry priority selection among the NCDB broadcast ports.
// For every ROB entry, reports whether any port targets it this cycle and the
// payload of the lowest-indexed such port. Purely combinational; used by both
// the entry write path and the optional lookup bypass.
// Ports:
//   cdb_valid/cdb_tag/cdb_data/cdb_addr/cdb_mispredict - flattened CDB inputs
//   hit_c, data_c, addr_c, mispredict_c                 - per-entry winners
module rob_cdb_merge
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned XLEN  = DEFAULT_XLEN,
    parameter int unsigned NCDB  = 2,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [NCDB-1:0]            cdb_valid,
    input  logic [NCDB*IDX_W-1:0]      cdb_tag,
    input  logic [NCDB*XLEN-1:0]       cdb_data,
    input  logic [NCDB*XLEN-1:0]       cdb_addr,
    input  logic [NCDB-1:0]            cdb_mispredict,
    output logic [DEPTH-1:0]           hit_c,
    output logic [DEPTH-1:0][XLEN-1:0] data_c,
    output logic [DEPTH-1:0][XLEN-1:0] addr_c,
    output logic [DEPTH-1:0]           mispredict_c
);

    // Ports are scanned high to low so the lowest matching port is the last
    // assignment and therefore wins.
    always_comb begin
        hit_c        = '0;
        data_c       = '0;
        addr_c       = '0;
        mispredict_c = '0;
        for (int e = 0; e < int'(DEPTH); e++) begin
            for (int p = int'(NCDB) - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_tag[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
                    hit_c[e]        = 1'b1;
                    data_c[e]       = cdb_data[p*XLEN +: XLEN];
                    addr_c[e]       = cdb_addr[p*XLEN +: XLEN];
                    mispredict_c[e] = cdb_mispredict[p];
                end
            end
        end
    end

endmodule

// File: rtl/rob_queue.sv
// rob_queue: parametrised reorder buffer. Allocates in program order, accepts
// results from NCDB broadcast ports, serves NLOOKUP operand lookups, and
// retires one entry per cycle in order.
// Ports:
//   clk, rst_n                              - clock, async active-low reset
//   alloc_valid/kind/sub/rd, alloc_ready,
//   alloc_tag                               - issue-side allocation (ready/tag comb)
//   cdb_valid/tag/data/addr/mispredict      - result broadcast ports
//   lookup_tag, lookup_ready, lookup_data   - operand lookup (comb)
//   commit_valid/tag, reg_*, mem_*,
//   redirect_valid/pc, flush                - registered one-cycle retire outputs
//   halt                                    - sticky after HALT retires
//   count                                   - occupied entries
// Macro: ROB_CDB_BYPASS_EN - lookups also see same-cycle CDB writes.
module rob_queue
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned XLEN    = DEFAULT_XLEN,
    parameter int unsigned NCDB    = 2,
    parameter int unsigned NLOOKUP = 2,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [2:0]               alloc_kind,
    input  logic [2:0]               alloc_sub,
    input  logic [4:0]               alloc_rd,
    output logic [IDX_W-1:0]         alloc_tag,
    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*IDX_W-1:0]    cdb_tag,
    input  logic [NCDB*XLEN-1:0]     cdb_data,
    input  logic [NCDB*XLEN-1:0]     cdb_addr,
    input  logic [NCDB-1:0]          cdb_mispredict,
    input  logic [NLOOKUP*IDX_W-1:0] lookup_tag,
    output logic [NLOOKUP-1:0]       lookup_ready,
    output logic [NLOOKUP*XLEN-1:0]  lookup_data,
    output logic                     commit_valid,
    output logic [IDX_W-1:0]         commit_tag,
    output logic                     reg_we,
    output logic [4:0]               reg_idx,
    output logic [XLEN-1:0]          reg_data,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_data,
    output logic [2:0]               mem_size,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     flush,
    output logic                     halt,
    output logic [IDX_W:0]           count
);

    rob_status_t     st_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] addr_q [DEPTH];
    logic [IDX_W-1:0] head_q, tail_q;
    logic [IDX_W:0]   count_q;
    logic             halt_q;

    rob_status_t head_st;
    rob_kind_e   alloc_kind_e;
    logic        full, head_go, flush_now, alloc_fire;
    logic [IDX_W-1:0] lk_tag;

    logic [DEPTH-1:0]           m_hit, m_misp;
    logic [DEPTH-1:0][XLEN-1:0] m_data, m_addr;

    // Registered retire outputs, next-value side.
    logic             cv_n, rwe_n, mwe_n, rv_n, fl_n;
    logic [IDX_W-1:0] ct_n;
    logic [4:0]       ridx_n;
    logic [2:0]       msize_n;
    logic [XLEN-1:0]  rdata_n, maddr_n, mdata_n, rpc_n;

    rob_cdb_merge #(.DEPTH(DEPTH), .XLEN(XLEN), .NCDB(NCDB)) u_merge (
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_addr       (cdb_addr),
        .cdb_mispredict (cdb_mispredict),
        .hit_c          (m_hit),
        .data_c         (m_data),
        .addr_c         (m_addr),
        .mispredict_c   (m_misp)
    );

    assign head_st      = st_q[head_q];
    assign alloc_kind_e = rob_kind_e'(alloc_kind);
    assign full         = (count_q == (IDX_W+1)'(DEPTH));
    assign head_go      = head_st.valid && head_st.ready && !halt_q;
    assign flush_now    = head_go && head_st.mispredict && kind_is_ctrl(head_st.kind);
    // A full ROB refuses allocation even while the head retires.
    assign alloc_ready  = !full && !halt_q && !flush_now;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign alloc_tag    = tail_q;
    assign count        = count_q;
    assign halt         = halt_q;

    // Entry storage, pointers, occupancy and halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i]   <= '0;
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else if (flush_now) begin
            // Mispredict retire: drop everything, including same-cycle writes.
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i].valid <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (m_hit[i] && st_q[i].valid) begin
                    st_q[i].ready      <= 1'b1;
                    st_q[i].mispredict <= m_misp[i];
                    data_q[i]          <= m_data[i];
                    addr_q[i]          <= m_addr[i];
                end
            end
            if (head_go) begin
                st_q[head_q].valid <= 1'b0;
                head_q             <= head_q + IDX_W'(1);
                if (head_st.kind == KIND_HALT) begin
                    halt_q <= 1'b1;
                end
            end
            if (alloc_fire) begin
                st_q[tail_q] <= '{valid:      1'b1,
                                  ready:      (alloc_kind_e == KIND_HALT),
                                  mispredict: 1'b0,
                                  kind:       alloc_kind_e,
                                  sub:        alloc_sub,
                                  rd:         alloc_rd};
                data_q[tail_q] <= '0;
                addr_q[tail_q] <= '0;
                tail_q         <= tail_q + IDX_W'(1);
            end
            count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(head_go);
        end
    end

    // Retire decode for the head entry.
    always_comb begin
        cv_n    = 1'b0;
        ct_n    = '0;
        rwe_n   = 1'b0;
        ridx_n  = '0;
        rdata_n = '0;
        mwe_n   = 1'b0;
        maddr_n = '0;
        mdata_n = '0;
        msize_n = '0;
        rv_n    = 1'b0;
        rpc_n   = '0;
        fl_n    = 1'b0;
        if (head_go) begin
            cv_n = 1'b1;
            ct_n = head_q;
            if (kind_writes_rd(head_st.kind) && (head_st.rd != '0)) begin
                rwe_n   = 1'b1;
                ridx_n  = head_st.rd;
                rdata_n = data_q[head_q];
            end
            if (head_st.kind == KIND_STORE) begin
                mwe_n   = 1'b1;
                maddr_n = addr_q[head_q];
                mdata_n = data_q[head_q];
                msize_n = head_st.sub;
            end
            if (flush_now) begin
                rv_n  = 1'b1;
                rpc_n = addr_q[head_q];
                fl_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid   <= 1'b0;
            commit_tag     <= '0;
            reg_we         <= 1'b0;
            reg_idx        <= '0;
            reg_data       <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            mem_size       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            commit_valid   <= cv_n;
            commit_tag     <= ct_n;
            reg_we         <= rwe_n;
            reg_idx        <= ridx_n;
            reg_data       <= rdata_n;
            mem_we         <= mwe_n;
            mem_addr       <= maddr_n;
            mem_data       <= mdata_n;
            mem_size       <= msize_n;
            redirect_valid <= rv_n;
            redirect_pc    <= rpc_n;
            flush          <= fl_n;
        end
    end

    // Operand lookup from stored state, optionally overridden by a same-cycle CDB hit.
    always_comb begin
        lookup_ready = '0;
        lookup_data  = '0;
        lk_tag       = '0;
        for (int l = 0; l < int'(NLOOKUP); l++) begin
            lk_tag                      = lookup_tag[l*IDX_W +: IDX_W];
            lookup_ready[l]             = st_q[lk_tag].valid && st_q[lk_tag].ready;
            lookup_data[l*XLEN +: XLEN] = data_q[lk_tag];
`ifdef ROB_CDB_BYPASS_EN
            if (st_q[lk_tag].valid && m_hit[lk_tag]) begin
                lookup_ready[l]             = 1'b1;
                lookup_data[l*XLEN +: XLEN] = m_data[lk_tag];
            end
`endif
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed + randomized bench for rob_queue. A queue-based
// program-order model predicts comb outputs each cycle and pushes expected
// retire records into a scoreboard; a negedge monitor pops and compares.
module tb_rob_queue;
    import rob_pkg::*;

    localparam int DEPTH = 16, XLEN = 32, NCDB = 2, NLOOKUP = 2, IDX_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alloc_valid = 1'b0, alloc_ready;
    logic [2:0] alloc_kind = '0, alloc_sub = '0;
    logic [4:0] alloc_rd = '0;
    logic [IDX_W-1:0] alloc_tag;
    logic [NCDB-1:0] cdb_valid = '0, cdb_mispredict = '0;
    logic [NCDB*IDX_W-1:0] cdb_tag = '0;
    logic [NCDB*XLEN-1:0] cdb_data = '0, cdb_addr = '0;
    logic [NLOOKUP*IDX_W-1:0] lookup_tag = '0;
    logic [NLOOKUP-1:0] lookup_ready;
    logic [NLOOKUP*XLEN-1:0] lookup_data;
    logic commit_valid, reg_we, mem_we, redirect_valid, flush, halt;
    logic [IDX_W-1:0] commit_tag;
    logic [4:0] reg_idx;
    logic [2:0] mem_size;
    logic [XLEN-1:0] reg_data, mem_addr, mem_data, redirect_pc;
    logic [IDX_W:0] count;

    always #5 clk = ~clk;

    rob_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NCDB(NCDB), .NLOOKUP(NLOOKUP)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
        .alloc_sub(alloc_sub), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_addr(cdb_addr),
        .cdb_mispredict(cdb_mispredict),
        .lookup_tag(lookup_tag), .lookup_ready(lookup_ready), .lookup_data(lookup_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .halt(halt), .count(count)
    );

    typedef struct {
        int          tag;
        logic [2:0]  kind;
        logic [2:0]  sub;
        logic [4:0]  rd;
        bit          ready;
        bit          misp;
        logic [31:0] data;
        logic [31:0] addr;
    } ment_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic        reg_we;
        logic [4:0]  reg_idx;
        logic [31:0] reg_data;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [2:0]  mem_size;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        flush;
    } cm_t;

    ment_t m_rob[$];
    cm_t   exp_q[$];
    int    m_tail = 0;
    bit    m_halt = 1'b0;
    int    n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_tag(input int t);
        for (int i = 0; i < m_rob.size(); i++) if (m_rob[i].tag == t) return i;
        return -1;
    endfunction

    // Retire monitor: each committed entry must match the oldest expectation.
    always @(negedge clk) begin : monitor
        cm_t act, e;
        if (rst_n) begin
            act = {commit_tag, reg_we, reg_idx, reg_data, mem_we, mem_addr, mem_data,
                   mem_size, redirect_valid, redirect_pc, flush};
            n_cmp++;
            if (commit_valid) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL commit_unexpected: got tag %0d, none expected at %0t", commit_tag, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL commit_record: got 0x%0h expected 0x%0h at %0t", act, e, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_bad++;
                $display("FAIL commit_missing: got none expected tag %0d at %0t", e.tag, $time);
            end else if ({reg_we, mem_we, redirect_valid, flush} != 4'b0) begin
                n_bad++;
                $display("FAIL idle_pulses: got 0x%0h expected 0x0 at %0t",
                         {reg_we, mem_we, redirect_valid, flush}, $time);
            end
        end
    end

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid = '0;
        cdb_mispredict = '0;
    endtask

    task automatic set_alloc(input logic [2:0] k, input logic [2:0] s, input logic [4:0] r);
        alloc_valid = 1'b1; alloc_kind = k; alloc_sub = s; alloc_rd = r;
    endtask

    task automatic set_cdb(input int p, input int t, input logic [31:0] d, input logic [31:0] a, input logic m);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*IDX_W +: IDX_W] = 4'(t);
        cdb_data[p*XLEN +: XLEN] = d;
        cdb_addr[p*XLEN +: XLEN] = a;
        cdb_mispredict[p] = m;
    endtask

    // One clock: predict and check comb outputs at negedge, advance model at posedge.
    task automatic step();
        bit hr, fl, ear, done[DEPTH];
        int idx, t, w;
        bit er;
        logic [31:0] ed;
        ment_t e;
        cm_t c;
        hr  = (m_rob.size() > 0) && m_rob[0].ready && !m_halt;
        fl  = hr && m_rob[0].misp && (m_rob[0].kind == KIND_BRANCH || m_rob[0].kind == KIND_JUMP);
        ear = (m_rob.size() < DEPTH) && !m_halt && !fl;
        @(negedge clk);
        chk("alloc_ready", alloc_ready, ear);
        if (ear) chk("alloc_tag", alloc_tag, m_tail);
        chk("count", count, m_rob.size());
        chk("halt", halt, m_halt);
        for (int l = 0; l < NLOOKUP; l++) begin
            t = int'(lookup_tag[l*IDX_W +: IDX_W]);
            idx = find_tag(t);
            er = 1'b0; ed = '0;
            if (idx >= 0) begin
                er = m_rob[idx].ready; ed = m_rob[idx].data;
`ifdef ROB_CDB_BYPASS_EN
                w = -1;
                for (int p = NCDB - 1; p >= 0; p--)
                    if (cdb_valid[p] && int'(cdb_tag[p*IDX_W +: IDX_W]) == t) w = p;
                if (w >= 0) begin er = 1'b1; ed = cdb_data[w*XLEN +: XLEN]; end
`endif
            end
            chk("lookup_ready", lookup_ready[l], er);
            if (er) chk("lookup_data", lookup_data[l*XLEN +: XLEN], ed);
        end
        @(posedge clk);
        if (hr) begin
            e = m_rob.pop_front();
            c = '0;
            c.tag = 4'(e.tag);
            if ((e.kind == KIND_ALU || e.kind == KIND_LOAD || e.kind == KIND_JUMP) && e.rd != 0) begin
                c.reg_we = 1'b1; c.reg_idx = e.rd; c.reg_data = e.data;
            end
            if (e.kind == KIND_STORE) begin
                c.mem_we = 1'b1; c.mem_addr = e.addr; c.mem_data = e.data; c.mem_size = e.sub;
            end
            if (fl) begin
                c.redirect_valid = 1'b1; c.redirect_pc = e.addr; c.flush = 1'b1;
            end
            if (e.kind == KIND_HALT) m_halt = 1'b1;
            exp_q.push_back(c);
        end
        if (fl) begin
            m_rob.delete();
            m_tail = 0;
        end else begin
            for (int i = 0; i < DEPTH; i++) done[i] = 1'b0;
            for (int p = 0; p < NCDB; p++) begin
                t = int'(cdb_tag[p*IDX_W +: IDX_W]);
                if (cdb_valid[p] && !done[t]) begin
                    done[t] = 1'b1;
                    idx = find_tag(t);
                    if (idx >= 0) begin
                        e = m_rob[idx];
                        e.ready = 1'b1; e.misp = cdb_mispredict[p];
                        e.data = cdb_data[p*XLEN +: XLEN]; e.addr = cdb_addr[p*XLEN +: XLEN];
                        m_rob[idx] = e;
                    end
                end
            end
            if (alloc_valid && ear) begin
                e = '{tag: m_tail, kind: alloc_kind, sub: alloc_sub, rd: alloc_rd,
                      ready: (alloc_kind == KIND_HALT), misp: 1'b0, data: 32'h0, addr: 32'h0};
                m_rob.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin idle(); step(); end
    endtask

    task automatic do_reset();
        idle();
        lookup_tag = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_pulses", {reg_we, mem_we, redirect_valid, flush}, 0);
        chk("rst_count", count, 0);
        m_rob.delete(); exp_q.delete(); m_tail = 0; m_halt = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int n);
        int t, i;
        logic m;
        for (int c = 0; c < n; c++) begin
            idle();
            if ($urandom % 4 != 0) set_alloc(3'($urandom % 5), 3'($urandom), 5'($urandom));
            for (int p = 0; p < NCDB; p++) begin
                if ($urandom % 2 == 1) begin
                    m = 1'b0;
                    if (m_rob.size() > 0 && $urandom % 8 != 0) begin
                        i = int'($urandom % m_rob.size());
                        t = m_rob[i].tag;
                        m = (m_rob[i].kind == KIND_BRANCH || m_rob[i].kind == KIND_JUMP) && ($urandom % 5 == 0);
                    end else begin
                        t = int'($urandom % DEPTH);
                    end
                    if (p == 1 && cdb_valid[0] && $urandom % 6 == 0) begin
                        t = int'(cdb_tag[IDX_W-1:0]); m = 1'b0;
                    end
                    set_cdb(p, t, $urandom, $urandom, m);
                end
            end
            lookup_tag = 8'($urandom);
            step();
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("reset_alloc_ready", alloc_ready, 1);
        chk("reset_halt", halt, 0);
        chk("reset_alloc_tag", alloc_tag, 0);

        // ALU rd=5, result next cycle, retire two edges after alloc.
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd5); step();
        idle(); set_cdb(0, 0, 32'h1234, 32'h0, 1'b0); step();
        drain(3);

        // Fill, refuse when full, single retire, then wrap of tail to 0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin idle(); set_alloc(KIND_ALU, 3'd0, 5'(i + 1)); step(); end
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd7); step();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd7); set_cdb(0, 0, 32'hAA, 32'h0, 1'b0); step();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd7); step();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd8); step();
        drain(2);

        // Store retires in order behind older ALUs.
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); set_alloc(KIND_ALU, 3'd0, 5'(i + 1)); step(); end
        idle(); set_alloc(KIND_STORE, 3'd0, 5'd0); step();
        idle(); set_cdb(0, 3, 32'hAB, 32'h100, 1'b0); set_cdb(1, 1, 32'h5, 32'h0, 1'b0); step();
        idle(); set_cdb(0, 0, 32'h6, 32'h0, 1'b0); set_cdb(1, 2, 32'h7, 32'h0, 1'b0); step();
        drain(6);

        // Mispredicted branch at head with four ready younger entries.
        do_reset();
        idle(); set_alloc(KIND_BRANCH, 3'd0, 5'd0); step();
        for (int i = 0; i < 4; i++) begin idle(); set_alloc(KIND_ALU, 3'd0, 5'(i + 10)); step(); end
        idle(); set_cdb(0, 1, 32'h1, 32'h0, 1'b0); set_cdb(1, 2, 32'h2, 32'h0, 1'b0); step();
        idle(); set_cdb(0, 3, 32'h3, 32'h0, 1'b0); set_cdb(1, 4, 32'h4, 32'h0, 1'b0); step();
        idle(); set_cdb(0, 0, 32'h0, 32'h40, 1'b1); step();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd1); step();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd2); step();
        drain(4);

        // Two ports on the same tag: lowest port wins (also via lookup).
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); set_alloc(KIND_ALU, 3'd0, 5'(i + 1)); step(); end
        idle(); set_cdb(0, 2, 32'h11, 32'h0, 1'b0); set_cdb(1, 2, 32'h22, 32'h0, 1'b0);
        lookup_tag = {4'd0, 4'd2}; step();
        idle(); step();
        idle(); set_cdb(0, 0, 32'h9, 32'h0, 1'b0); set_cdb(1, 1, 32'hA, 32'h0, 1'b0); step();
        drain(5);

        // HALT retires, then everything stops until reset.
        do_reset();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd3); step();
        idle(); set_alloc(KIND_HALT, 3'd0, 5'd0); step();
        idle(); set_alloc(KIND_ALU, 3'd0, 5'd4); set_cdb(0, 0, 32'h33, 32'h0, 1'b0); step();
        idle(); set_cdb(0, 2, 32'h44, 32'h0, 1'b0); step();
        for (int i = 0; i < 8; i++) begin idle(); set_alloc(KIND_ALU, 3'd0, 5'd6); step(); end

        // Randomized traffic against the model.
        do_reset();
        run_random(3000);
        drain(40);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
